// File: rtl/pipe_result_collector.sv
// pipe_result_collector: token-tracked capture of fixed-latency netlist outputs into a credit-guarded result FIFO (optional SEQ_TAG_EN adds sequence tags)
module pipe_result_collector #(
  parameter int NOUT   = 2,
  parameter int LAT    = 4,
  parameter int FDEPTH = 4,
  parameter int TAGW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            launch,
  output logic            launch_ok,
  input  logic [NOUT-1:0] pipe_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOUT-1:0] out_data,
  output logic            err_ovf
`ifdef SEQ_TAG_EN
  ,
  output logic [TAGW-1:0] out_tag
`endif
);
  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;
  if (LAT < 1 || LAT > 64 || FDEPTH < 2 || FDEPTH > 256 || (FDEPTH & (FDEPTH - 1)) != 0 || NOUT < 1 || TAGW < 1) begin : g_bad_param
    $error("pipe_result_collector: illegal parameter set");
  end
  logic [LAT-1:0]  tok_q, tok_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NOUT-1:0] mem_q [FDEPTH];
  logic [9:0]      used;
  logic            acc, push, pop;
  // credits count every token still in the line plus every buffered result, so a capture always finds room
  always_comb begin
    used      = 10'($countones(tok_q)) + 10'(cnt_q);
    launch_ok = used < 10'(FDEPTH);
    out_valid = cnt_q != '0;
    out_data  = out_valid ? mem_q[rd_q] : '0;
    acc       = launch & launch_ok;
    push      = tok_q[LAT-1];
    pop       = out_valid & out_ready;
    tok_d     = (tok_q << 1) | LAT'(acc);
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    err_d     = err_q | (launch & ~launch_ok);
  end
  assign err_ovf = err_q;
  // control state: token line, FIFO pointers and occupancy, sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tok_q <= tok_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // result storage; contents are only meaningful below the occupancy count, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pipe_out;
  end
`ifdef SEQ_TAG_EN
  logic [TAGW-1:0] seq_q, seq_d;
  logic [TAGW-1:0] tagp_q [LAT];
  logic [TAGW-1:0] tmem_q [FDEPTH];
  // next sequence number advances per accepted launch; head tag is zero while empty
  always_comb begin
    seq_d   = seq_q + TAGW'(acc);
    out_tag = out_valid ? tmem_q[rd_q] : '0;
  end
  // launch counter
  always_ff @(posedge clk) begin
    if (rst) seq_q <= '0;
    else seq_q <= seq_d;
  end
  // tag line runs in lockstep with the token line and lands in the FIFO beside its data
  always_ff @(posedge clk) begin
    tagp_q[0] <= seq_q;
    for (int i = 1; i < LAT; i++) tagp_q[i] <= tagp_q[i-1];
    if (push) tmem_q[wr_q] <= tagp_q[LAT-1];
  end
`endif
endmodule

// File: tb/tb_pipe_result_collector.sv
// tb_pipe_result_collector: directed and randomized checks against a queue-based reference model
module tb_pipe_result_collector;
  localparam int LAT = 4;
  localparam int FD  = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, launch = 1'b0, out_ready = 1'b0;
  logic [3:0] pipe_out = '0, out_data;
  logic launch_ok, out_valid, err_ovf;
  logic rst8 = 1'b1, launch8 = 1'b0, ready8 = 1'b0;
  logic [7:0] pout8 = '0, data8;
  logic ok8, valid8, err8;
`ifdef SEQ_TAG_EN
  logic [1:0] out_tag;
  logic [7:0] tag8;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0;
  int lt[$];
  int lg[$];
  int rq[$];
  int rg[$];
  bit m_err = 0;
  int m_seq = 0;

  pipe_result_collector #(.NOUT(4), .LAT(LAT), .FDEPTH(FD), .TAGW(2)) u_dut (
    .clk(clk), .rst(rst), .launch(launch), .launch_ok(launch_ok), .pipe_out(pipe_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_ovf(err_ovf)
`ifdef SEQ_TAG_EN
    , .out_tag(out_tag)
`endif
  );

  pipe_result_collector #(.NOUT(8), .LAT(4), .FDEPTH(8), .TAGW(8)) u_dut8 (
    .clk(clk), .rst(rst8), .launch(launch8), .launch_ok(ok8), .pipe_out(pout8),
    .out_valid(valid8), .out_ready(ready8), .out_data(data8), .err_ovf(err8)
`ifdef SEQ_TAG_EN
    , .out_tag(tag8)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_ok();
    return (lt.size() + rq.size()) < FD;
  endfunction

  task automatic step(input logic r, input logic l, input logic rd, input logic [3:0] p);
    bit ok;
    rst = r; launch = l; out_ready = rd; pipe_out = p;
    ok = m_ok();
    @(posedge clk);
    if (r) begin
      lt.delete(); lg.delete(); rq.delete(); rg.delete();
      m_err = 0; m_seq = 0;
    end else begin
      if (rd && rq.size() > 0) begin
        void'(rq.pop_front());
        void'(rg.pop_front());
      end
      if (lt.size() > 0 && lt[0] == cyc - LAT) begin
        void'(lt.pop_front());
        rq.push_back(int'(p));
        rg.push_back(lg.pop_front());
      end
      if (l && !ok) m_err = 1;
      if (l && ok) begin
        lt.push_back(cyc);
        lg.push_back(m_seq % 4);
        m_seq++;
      end
    end
    cyc++;
    @(negedge clk);
    check("out_valid", out_valid, rq.size() != 0);
    check("out_data", out_data, rq.size() != 0 ? rq[0] : 0);
    check("launch_ok", launch_ok, m_ok());
    check("err_ovf", err_ovf, m_err);
`ifdef SEQ_TAG_EN
    check("out_tag", out_tag, rg.size() != 0 ? rg[0] : 0);
`endif
  endtask

  task automatic reset_main();
    step(1, 0, 0, 0);
    cyc = 0;
  endtask

  task automatic step8(input logic r, input logic l, input logic rd, input logic [7:0] p);
    rst8 = r; launch8 = l; ready8 = rd; pout8 = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    @(negedge clk);
    reset_main();
    check("rst_valid", out_valid, 0);
    check("rst_ok", launch_ok, 1);
    check("rst_err", err_ovf, 0);
    step(0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, k == 4 ? 4'b0010 : 4'b0000);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 2);
    step(0, 0, 1, 0);
    check("t1_popped", out_valid, 0);

    reset_main();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 4'($urandom));
      if (i == 3) check("t2_ok_low", launch_ok, 0);
    end
    check("t2_err", err_ovf, 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      step(0, 0, 1, 4'($urandom));
    end
    check("t2_results", n, 4);
    check("t2_err_sticky", err_ovf, 1);

    reset_main();
    check("t3_err_clr", err_ovf, 0);
    for (int k = 0; k < 8; k++) step(0, k < 4, 0, 4'(k - 3));
    check("t3_full_ok", launch_ok, 0);
    check("t3_head1", out_data, 1);
    step(0, 0, 1, 0);
    check("t3_credit", launch_ok, 1);
    step(0, 1, 0, 0);
    for (int k = 10; k <= 13; k++) step(0, 0, 0, k == 13 ? 4'd5 : 4'd0);
    for (int j = 0; j < 4; j++) begin
      check("t3_order", out_data, j + 2);
      step(0, 0, 1, 0);
    end
    check("t3_drained", out_valid, 0);

`ifdef SEQ_TAG_EN
    reset_main();
    n = 0;
    begin
      int got = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid) begin
          check("t6_tag", out_tag, got % 4);
          got++;
        end
        step(0, m_ok() && n < 6, 1, 4'($urandom));
        if (launch && m_seq > n) n = m_seq;
      end
      check("t6_count", got, 6);
    end
`endif

    reset_main();
    for (int i = 0; i < 600; i++) begin
      bit busy;
      busy = (i / 100) % 2 == 1;
      if ($urandom % 150 == 0) step(1, 0, 0, 0);
      else step(0, m_ok() ? ($urandom % 4 != 0) : ($urandom % 60 == 0),
                busy ? ($urandom % 4 == 0) : ($urandom % 4 != 0), 4'($urandom));
    end

    step8(1, 0, 0, 0);
    step8(0, 1, 0, 0);
    step8(0, 1, 0, 0);
    for (int k = 2; k < 6; k++) step8(0, 0, 0, 8'(k));
    for (int k = 6; k < 9; k++) step8(0, 1, 0, 8'(k));
    check("t5_pre_valid", valid8, 1);
    step8(1, 0, 0, 0);
    check("t5_valid", valid8, 0);
    check("t5_ok", ok8, 1);
    n = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      step8(0, 0, 1, 8'hA5);
      if (valid8) n++;
    end
    check("t5_no_result", n, 0);

    step8(1, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step8(0, 1, 1, 8'(k));
      if (!ok8) n++;
      if (k + 1 >= LAT + 1) begin
        check("t4_valid", valid8, 1);
        check("t4_data", data8, k);
      end
    end
    check("t4_ok_never_low", n, 0);
    check("t4_err", err8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
